lane_aligner_reset_sequencer: RTL

Multi-lane successor to the single-lane byte-aligner reset generator. Holds each lane's byte aligner in reset for a programmable number of byte clocks after system reset. Then waits for the aligner to report sync, retrying on timeout, and re-arms on request, for example at LP-11 entry between packets. Sits between the D-PHY lane receivers and the per-lane byte aligners, and feeds the lane merger with a global lock flag.

---
 rtl/lane_aligner_reset_sequencer_pkg.sv | 30 +++
 rtl/lane_aligner_reset_sequencer_lane_fsm.sv | 92 +++++++++
 rtl/lane_aligner_reset_sequencer.sv | 48 ++++
 3 files changed

// File: rtl/lane_aligner_reset_sequencer_pkg.sv
// Shared definitions for the multi-lane byte-aligner reset sequencer:
// lane FSM state encoding and counter width helpers.
package lane_aligner_reset_sequencer_pkg;

  // Legacy-compatible state codes, also used as the enum values below
  localparam logic [1:0] ST_HOLD       = 2'd0;
  localparam logic [1:0] ST_WAIT_ALIGN = 2'd1;
  localparam logic [1:0] ST_LOCKED     = 2'd2;
  localparam logic [1:0] ST_FAIL       = 2'd3;

  typedef enum logic [1:0] {
    HOLD       = ST_HOLD,
    WAIT_ALIGN = ST_WAIT_ALIGN,
    LOCKED     = ST_LOCKED,
    FAIL       = ST_FAIL
  } lane_state_t;

  // Number of bits needed to hold every value 0..max_value (at least 1)
  function automatic int width_for(input int max_value);
    int w;
    w = 1;
    while ((1 << w) <= max_value) w++;
    return w;
  endfunction

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lane_aligner_reset_sequencer_lane_fsm.sv
// One lane's reset sequencer: holds the byte aligner in reset, waits for
// sync with a bounded number of timeout retries, and re-arms on request.
module lane_reset_fsm
  import lane_aligner_reset_sequencer_pkg::*;
#(
  parameter int HOLD_CYCLES    = 5,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int MAX_RETRIES    = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic rearm,
  input  logic aligned,
  output logic aligner_reset,
  output logic locked,
  output logic error
);

  localparam int CNT_W = width_for(max_of(HOLD_CYCLES, TIMEOUT_CYCLES));
  localparam int RTY_W = width_for(MAX_RETRIES);

  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST =
    CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};
  localparam logic [RTY_W-1:0] RETRY_LIMIT  = RTY_W'(MAX_RETRIES);
  localparam bit               TIMEOUT_EN   = (TIMEOUT_CYCLES != 0);

  lane_state_t      state, state_d;
  logic [CNT_W-1:0] count, count_d;
  logic [RTY_W-1:0] retries, retries_d;

  // Next-state logic; disable beats rearm, rearm beats aligned, aligned beats timeout
  always_comb begin
    state_d   = state;
    count_d   = count;
    retries_d = retries;
    if (!enable || rearm) begin
      state_d   = HOLD;
      count_d   = '0;
      retries_d = '0;
    end else begin
      case (state)
        HOLD: begin
          if (count == HOLD_LAST) begin
            state_d = WAIT_ALIGN;
            count_d = '0;
          end else begin
            count_d = count + 1'b1;
          end
        end
        WAIT_ALIGN: begin
          if (aligned) begin
            state_d   = LOCKED;
            count_d   = '0;
            retries_d = '0;
          end else if (TIMEOUT_EN && (count == TIMEOUT_LAST)) begin
            retries_d = retries + 1'b1;
            count_d   = '0;
            state_d   = (retries_d == RETRY_LIMIT) ? FAIL : HOLD;
          end else if (count != CNT_MAX) begin
            count_d = count + 1'b1;
          end
        end
        default: begin
          state_d = state;
        end
      endcase
    end
  end

  // State, counters and outputs registered together so outputs track state exactly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= HOLD;
      count         <= '0;
      retries       <= '0;
      aligner_reset <= 1'b1;
      locked        <= 1'b0;
      error         <= 1'b0;
    end else begin
      state         <= state_d;
      count         <= count_d;
      retries       <= retries_d;
      aligner_reset <= (state_d == HOLD) || (state_d == FAIL);
      locked        <= (state_d == LOCKED);
      error         <= (state_d == FAIL);
    end
  end

endmodule

// File: rtl/lane_aligner_reset_sequencer.sv
// Multi-lane byte-aligner reset sequencer: one independent lane FSM per
// data lane plus a registered global lock flag for the lane merger.
module lane_aligner_reset_sequencer
  import lane_aligner_reset_sequencer_pkg::*;
#(
  parameter int LANES          = 4,
  parameter int HOLD_CYCLES    = 5,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int MAX_RETRIES    = 3
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic [LANES-1:0] lane_enable_i,
  input  logic [LANES-1:0] rearm_i,
  input  logic [LANES-1:0] aligned_i,
  output logic [LANES-1:0] aligner_reset_o,
  output logic [LANES-1:0] lane_locked_o,
  output logic [LANES-1:0] lane_error_o,
  output logic             all_locked_o
);

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    lane_reset_fsm #(
      .HOLD_CYCLES   (HOLD_CYCLES),
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
      .MAX_RETRIES   (MAX_RETRIES)
    ) u_fsm (
      .clk          (clk_i),
      .rst_n        (reset_n_i),
      .enable       (lane_enable_i[g]),
      .rearm        (rearm_i[g]),
      .aligned      (aligned_i[g]),
      .aligner_reset(aligner_reset_o[g]),
      .locked       (lane_locked_o[g]),
      .error        (lane_error_o[g])
    );
  end

  // Global lock: every enabled lane locked and at least one lane enabled
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      all_locked_o <= 1'b0;
    end else begin
      all_locked_o <= (&(lane_locked_o | ~lane_enable_i)) & (|lane_enable_i);
    end
  end

endmodule
